// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: accepts one load/store, stalls the pipeline for LATENCY cycles, then pulses ready.
// Optional misaligned-access checking is enabled by defining DMEM_MISALIGN_CHK_EN.
module dmem_responder #(
   parameter int DEPTH   = 256,
   parameter int LATENCY = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        mem_rd,
   input  logic        mem_wr,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        ready,
   output logic        stall,
   output logic        err
);

   localparam int AW = $clog2(DEPTH);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] WAIT = 2'd1;
   localparam logic [1:0] RESP = 2'd2;

   logic [1:0]    state;
   logic [3:0]    cnt;
   logic [3:0]    cnt_dec;
   logic [AW-1:0] idx_q;
   logic [31:0]   wdata_q;
   logic          wr_q;
   logic          bad_q;
   logic [31:0]   mem [DEPTH];

   logic          req;
   logic          bad_now;
   logic          enter_resp;
   logic [AW-1:0] acc_idx;
   logic          acc_wr;
   logic          acc_bad;
   logic          unused_addr_bits;

   assign req = mem_rd | mem_wr;

`ifdef DMEM_MISALIGN_CHK_EN
   assign bad_now          = (addr[1:0] != 2'b00);
   assign unused_addr_bits = ^addr[31:AW+2];
`else
   assign bad_now          = 1'b0;
   assign unused_addr_bits = ^{addr[31:AW+2], addr[1:0]};
`endif

   // The access that completes on this edge comes straight from the ports when
   // LATENCY=1 (IDLE jumps to RESP), otherwise from the latched request.
   // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
   always_comb begin
      acc_idx    = idx_q;
      acc_wr     = wr_q;
      acc_bad    = bad_q;
      enter_resp = 1'b0;
      cnt_dec    = cnt - 4'd1;
      case (state)
         IDLE: begin
            acc_idx    = addr[AW+1:2];
            acc_wr     = mem_wr;
            acc_bad    = bad_now;
            enter_resp = req && (LATENCY == 1);
         end
         WAIT:    enter_resp = (cnt_dec == 4'd0);
         default: ;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         cnt     <= 4'd0;
         idx_q   <= '0;
         wdata_q <= 32'd0;
         wr_q    <= 1'b0;
         bad_q   <= 1'b0;
         rdata   <= 32'd0;
         err     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (req) begin
                  idx_q   <= addr[AW+1:2];
                  wdata_q <= wdata;
                  wr_q    <= mem_wr;
                  bad_q   <= bad_now;
                  cnt     <= 4'(LATENCY - 1);
                  state   <= (LATENCY == 1) ? RESP : WAIT;
               end
            end
            WAIT: begin
               cnt <= cnt_dec;
               if (cnt_dec == 4'd0) state <= RESP;
            end
            default: state <= IDLE;
         endcase

         // err is only high for the RESP cycle, alongside ready.
         if (enter_resp) begin
            err <= acc_bad;
            if (!acc_wr) rdata <= acc_bad ? 32'd0 : mem[acc_idx];
         end else begin
            err <= 1'b0;
         end
      end
   end

   // NOTE: the storage array is deliberately not reset; a reset forces IDLE, which also aborts any pending write.
   always_ff @(posedge clk) begin
      if (state == RESP && wr_q && !bad_q) mem[idx_q] <= wdata_q;
   end

   assign ready = (state == RESP);
   assign stall = rst_n && ((state == IDLE && req) || state == WAIT);

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 256, meaning number of 32-bit words stored (power of two, 16..4096).
REQ-002 SHALL have parameter LATENCY, default 2, meaning cycles from request acceptance to ready (legal 1..15).
REQ-003 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port mem_rd  input  1  read request from the control path.
REQ-006 SHALL have port mem_wr  input  1  write request from the control path.
REQ-007 SHALL have port addr  input  32  byte address (ALU result).
REQ-008 SHALL have port wdata  input  32  store data (Rt value).
REQ-009 SHALL have port rdata  output  32  load data returned to write-back mux.
REQ-010 SHALL have port ready  output  1  one-cycle completion pulse.
REQ-011 SHALL have port stall  output  1  freeze PC and pipeline registers while high.
REQ-012 SHALL have port err  output  1  misaligned-access flag, valid with ready.

Function
REQ-013 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-014 SHALL, in IDLE, accept a request when mem_rd or mem_wr is 1: latch addr, wdata, op; load wait counter with LATENCY-1; go to WAIT, or directly to RESP if LATENCY=1.
REQ-015 SHALL give mem_wr priority when mem_rd and mem_wr are both 1 (treated as write).
REQ-016 SHALL, in WAIT, decrement the counter each cycle and go to RESP when it reaches 0.
REQ-017 SHALL drive stall = (IDLE and request present) or state==WAIT, combinationally; stall SHALL be 0 in RESP.
REQ-018 SHALL assert ready for exactly one cycle in RESP, LATENCY cycles after the acceptance edge, then return to IDLE.
REQ-019 SHALL ignore mem_rd/mem_wr while in WAIT or RESP; a request held during the RESP cycle is re-evaluated only in the following IDLE cycle.
REQ-020 SHALL index the array with latched addr[log2(DEPTH)+1:2]; upper address bits ignored (wrap-around modulo DEPTH words).
REQ-021 SHALL register read data into rdata on the edge entering RESP; rdata holds its value until the next read completion.
REQ-022 SHALL commit a write to the array on the edge leaving RESP; a read of the same word in the next request returns the new data.
REQ-023 SHALL leave rdata unchanged on write completions.

Reset
REQ-024 SHALL, on rst_n low, immediately force state IDLE, counter 0, rdata 0, ready 0, err 0, stall 0 regardless of clock.
REQ-025 SHALL abort an in-flight request on reset with no array write performed.
REQ-026 SHALL NOT clear array contents on reset; contents are undefined until written.

Configuration
REQ-027 SHALL, when DMEM_MISALIGN_CHK_EN is defined, flag latched addr[1:0] != 0: err=1 with ready, array not written, rdata forced to 0 on reads; latency unchanged.
REQ-028 SHALL, when DMEM_MISALIGN_CHK_EN is undefined, ignore addr[1:0] and tie err to 0.

Verification (LATENCY=2, DEPTH=256)
REQ-029 SHALL verify write addr=0x10 wdata=0xDEADBEEF then read addr=0x10 -> ready 2 cycles after each acceptance, stall high 2 cycles each, rdata=0xDEADBEEF.
REQ-030 SHALL verify wrap: write addr=0x400 wdata=0x12345678, read addr=0x0 -> rdata=0x12345678.
REQ-031 SHALL verify simultaneous mem_rd=mem_wr=1 at addr=0x20 wdata=0xA5A5A5A5 -> treated as write, rdata unchanged, later read of 0x20 returns 0xA5A5A5A5.
REQ-032 SHALL verify rst_n pulsed low in WAIT of write addr=0x30 wdata=0x1 (word previously 0x7) -> outputs zero at once, read of 0x30 after reset returns 0x7.
REQ-033 SHALL verify with DMEM_MISALIGN_CHK_EN: read addr=0x11 -> err=1, rdata=0 with ready; write addr=0x13 -> err=1, word 0x10 unchanged; without macro read addr=0x11 returns word 0x10, err=0.
REQ-034 SHALL verify LATENCY=1 build: read accepted at cycle T -> ready at T+1, stall high only in cycle T.
